// File: rtl/wvb_reader_rr.sv
// Waveform-buffer reader front end: masked round-robin over channel buffers with
// per-grant record bursts, header/read-controller sequencing and DPRAM run/busy handshake.
module wvb_reader_rr #(
  parameter int unsigned N_CHANNELS   = 8,
  parameter int unsigned P_DATA_WIDTH = 22,
  parameter int unsigned P_HDR_WIDTH  = 80,
  parameter int unsigned P_IDX_WIDTH  = 5,
  parameter int unsigned P_BURST_MAX  = 4,
  parameter int unsigned P_HDR_WT_CNT = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               en,
  input  logic [N_CHANNELS-1:0]              chan_mask,
  input  logic [N_CHANNELS-1:0]              hdr_empty,
  input  logic [N_CHANNELS*P_HDR_WIDTH-1:0]  hdr_data,
  input  logic [N_CHANNELS*P_DATA_WIDTH-1:0] wvb_data,
  output logic [N_CHANNELS-1:0]              hdr_rdreq,
  output logic [N_CHANNELS-1:0]              wvb_rdreq,
  output logic [N_CHANNELS-1:0]              wvb_rddone,
  output logic                               rc_req,
  input  logic                               rc_ack,
  input  logic                               rc_more,
  input  logic [15:0]                        rc_len,
  input  logic                               rc_wvb_rdreq,
  input  logic                               rc_wvb_rddone,
  output logic [P_IDX_WIDTH-1:0]             rc_idx,
  output logic [P_HDR_WIDTH-1:0]             rc_hdr,
  output logic [P_DATA_WIDTH-1:0]            rc_wvb,
  input  logic                               dpram_busy,
  input  logic                               dpram_mode,
  output logic                               dpram_run,
  output logic [15:0]                        dpram_len,
  output logic [31:0]                        rec_cnt
);

  localparam int unsigned WT_W  = $clog2(P_HDR_WT_CNT + 1);
  localparam int unsigned BST_W = $clog2(P_BURST_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_WAIT, S_RC_REQ, S_DPRAM_RUN, S_DPRAM_BUSY, S_DPRAM_DONE
  } state_t;

  state_t                            state, state_n;
  logic [P_IDX_WIDTH-1:0]            ptr, ptr_n, rc_idx_n, winner;
  logic [WT_W-1:0]                   wt_cnt, wt_cnt_n;
  logic [BST_W-1:0]                  burst, burst_n;
  logic [N_CHANNELS-1:0]             hdr_rdreq_n, eligible, sel_oh;
  logic                              rc_req_n, dpram_run_n, any_elig, cur_elig;
  logic [15:0]                       dpram_len_n;
  logic [31:0]                       rec_cnt_n;
  logic [N_CHANNELS*P_HDR_WIDTH-1:0] hdr_q;
  logic [N_CHANNELS*P_DATA_WIDTH-1:0] wvb_q;
  logic [P_HDR_WIDTH-1:0]            hdr_sel;
  logic [P_DATA_WIDTH-1:0]           wvb_sel;

  // First eligible channel strictly after 'last', wrapping around.
  function automatic logic [P_IDX_WIDTH-1:0] rr_pick(input logic [N_CHANNELS-1:0] elig,
                                                     input logic [P_IDX_WIDTH-1:0] last);
    logic [P_IDX_WIDTH-1:0] pick;
    logic [N_CHANNELS-1:0]  shifted;
    logic                   found;
    int unsigned            c;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N_CHANNELS; k++) begin
      c       = (32'(last) + k) % N_CHANNELS;
      shifted = elig >> c;
      if (!found && shifted[0]) begin
        pick  = P_IDX_WIDTH'(c);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign eligible   = chan_mask & ~hdr_empty;
  assign any_elig   = |eligible;
  assign sel_oh     = N_CHANNELS'(1) << rc_idx;
  assign cur_elig   = |(eligible & sel_oh);
  assign winner     = rr_pick(eligible, ptr);
  assign wvb_rdreq  = {N_CHANNELS{rc_wvb_rdreq}} & sel_oh;
  assign wvb_rddone = {N_CHANNELS{rc_wvb_rddone}} & sel_oh;

  // Second datapath stage: select the granted channel from the input registers.
  always_comb begin
    hdr_sel = '0;
    wvb_sel = '0;
    for (int unsigned i = 0; i < N_CHANNELS; i++) begin
      if (rc_idx == P_IDX_WIDTH'(i)) begin
        hdr_sel = hdr_q[i*P_HDR_WIDTH +: P_HDR_WIDTH];
        wvb_sel = wvb_q[i*P_DATA_WIDTH +: P_DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    rc_idx_n    = rc_idx;
    wt_cnt_n    = wt_cnt;
    burst_n     = burst;
    hdr_rdreq_n = '0;
    rc_req_n    = rc_req;
    dpram_run_n = 1'b0;
    dpram_len_n = dpram_len;
    rec_cnt_n   = rec_cnt;
    case (state)
      S_IDLE: begin
        if (any_elig && !dpram_busy && !rc_ack) begin
          state_n     = S_HDR_WAIT;
          rc_idx_n    = winner;
          ptr_n       = winner;
          hdr_rdreq_n = N_CHANNELS'(1) << winner;
          wt_cnt_n    = '0;
        end
      end
      S_HDR_WAIT: begin
        if (wt_cnt == WT_W'(P_HDR_WT_CNT - 1)) begin
          state_n  = S_RC_REQ;
          rc_req_n = 1'b1;
        end else begin
          wt_cnt_n = wt_cnt + 1'b1;
        end
      end
      S_RC_REQ: begin
        rc_req_n = 1'b1;
        if (rc_ack) begin
          rc_req_n    = 1'b0;
          dpram_len_n = rc_len;
          state_n     = S_DPRAM_RUN;
        end
      end
      S_DPRAM_RUN: begin
        if (!dpram_busy) begin
          dpram_run_n = 1'b1;
          state_n     = S_DPRAM_BUSY;
        end
      end
      S_DPRAM_BUSY: begin
        if (dpram_busy) state_n = S_DPRAM_DONE;
      end
      S_DPRAM_DONE: begin
        if (!dpram_busy) begin
          if (dpram_mode && rc_more) begin
            // Record spills into the next DPRAM: same record, burst untouched.
            if (!rc_ack) begin
              state_n  = S_RC_REQ;
              rc_req_n = 1'b1;
            end
          end else begin
            rec_cnt_n = rec_cnt + 32'd1;
            if (cur_elig && (32'(burst) + 32'd1 < P_BURST_MAX)) begin
              burst_n     = burst + 1'b1;
              state_n     = S_HDR_WAIT;
              hdr_rdreq_n = sel_oh;
              wt_cnt_n    = '0;
            end else begin
              burst_n = '0;
              state_n = S_IDLE;
            end
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      state     <= S_IDLE;
      ptr       <= P_IDX_WIDTH'(N_CHANNELS - 1);
      rc_idx    <= '0;
      wt_cnt    <= '0;
      burst     <= '0;
      hdr_rdreq <= '0;
      rc_req    <= 1'b0;
      dpram_run <= 1'b0;
      dpram_len <= '0;
      rec_cnt   <= '0;
      hdr_q     <= '0;
      wvb_q     <= '0;
      rc_hdr    <= '0;
      rc_wvb    <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      rc_idx    <= rc_idx_n;
      wt_cnt    <= wt_cnt_n;
      burst     <= burst_n;
      hdr_rdreq <= hdr_rdreq_n;
      rc_req    <= rc_req_n;
      dpram_run <= dpram_run_n;
      dpram_len <= dpram_len_n;
      rec_cnt   <= rec_cnt_n;
      hdr_q     <= hdr_data;
      wvb_q     <= wvb_data;
      rc_hdr    <= hdr_sel;
      rc_wvb    <= wvb_sel;
    end
  end

endmodule

// File: tb/tb_wvb_reader_rr.sv
// Scoreboard bench for wvb_reader_rr: queued header FIFOs, a read-controller/DPRAM
// responder and a round-robin/burst reference model predicting the grant order.
`timescale 1ns/1ps
module tb_wvb_reader_rr;

  localparam int unsigned N  = 8;
  localparam int unsigned DW = 22;
  localparam int unsigned HW = 80;
  localparam int unsigned IW = 5;
  localparam int unsigned BM = 4;
  localparam int unsigned WT = 3;

  logic              clk = 1'b0;
  logic              rst_n, en;
  logic [N-1:0]      chan_mask, hdr_empty;
  logic [N*HW-1:0]   hdr_data;
  logic [N*DW-1:0]   wvb_data;
  logic [N-1:0]      hdr_rdreq, wvb_rdreq, wvb_rddone;
  logic              rc_req, rc_ack, rc_more, rc_wvb_rdreq, rc_wvb_rddone;
  logic [15:0]       rc_len, dpram_len;
  logic [IW-1:0]     rc_idx;
  logic [HW-1:0]     rc_hdr;
  logic [DW-1:0]     rc_wvb;
  logic              dpram_busy, dpram_mode, dpram_run;
  logic [31:0]       rec_cnt;

  int  loaded[N];
  int  popped[N];
  int  exp_ch[$];
  int  exp_len[$];
  int  cur_ch;
  int  rec_done;
  int  base;
  int  n_cmp, n_bad;
  bit  mon_en, abort;
  logic [N*DW-1:0] hist1, hist2;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) hdr_empty[i] = (loaded[i] == popped[i]);
  end

  wvb_reader_rr #(
    .N_CHANNELS(N), .P_DATA_WIDTH(DW), .P_HDR_WIDTH(HW), .P_IDX_WIDTH(IW),
    .P_BURST_MAX(BM), .P_HDR_WT_CNT(WT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .chan_mask(chan_mask), .hdr_empty(hdr_empty),
    .hdr_data(hdr_data), .wvb_data(wvb_data), .hdr_rdreq(hdr_rdreq), .wvb_rdreq(wvb_rdreq),
    .wvb_rddone(wvb_rddone), .rc_req(rc_req), .rc_ack(rc_ack), .rc_more(rc_more),
    .rc_len(rc_len), .rc_wvb_rdreq(rc_wvb_rdreq), .rc_wvb_rddone(rc_wvb_rddone),
    .rc_idx(rc_idx), .rc_hdr(rc_hdr), .rc_wvb(rc_wvb), .dpram_busy(dpram_busy),
    .dpram_mode(dpram_mode), .dpram_run(dpram_run), .dpram_len(dpram_len), .rec_cnt(rec_cnt)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: serve channels in circular order after the last winner, up to BM records each.
  task automatic build_model(input logic [N-1:0] mask, output int total);
    int cnt[N];
    int ptr, win, b;
    for (int i = 0; i < N; i++) cnt[i] = loaded[i] - popped[i];
    ptr   = N - 1;
    total = 0;
    forever begin
      win = -1;
      for (int k = 1; k <= N; k++)
        if (win < 0 && mask[(ptr + k) % N] && cnt[(ptr + k) % N] > 0) win = (ptr + k) % N;
      if (win < 0) break;
      ptr = win;
      b   = 0;
      while (b < BM && cnt[win] > 0) begin
        exp_ch.push_back(win);
        cnt[win]--;
        b++;
        total++;
      end
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_hdr_rdreq"}, hdr_rdreq, 0);
    chk({tag, "_rc_req"},    rc_req,    0);
    chk({tag, "_rc_idx"},    rc_idx,    0);
    chk({tag, "_rc_hdr"},    rc_hdr,    0);
    chk({tag, "_rc_wvb"},    rc_wvb,    0);
    chk({tag, "_dpram_run"}, dpram_run, 0);
    chk({tag, "_dpram_len"}, dpram_len, 0);
    chk({tag, "_rec_cnt"},   rec_cnt,   0);
  endtask

  task automatic begin_round(input bit mode, input logic [N-1:0] mask,
                             input logic [N-1:0] model_mask, input bit use_en, output int total);
    @(negedge clk);
    mon_en     = 1'b0;
    abort      = 1'b1;
    dpram_mode = mode;
    chan_mask  = mask;
    if (use_en) en = 1'b0; else rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_ch.delete();
    build_model(model_mask, total);
    for (int i = 0; i < N; i++) hdr_data[i*HW +: HW] = {16'(i), $urandom, $urandom};
    base   = rec_done;
    abort  = 1'b0;
    en     = 1'b1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic finish_round(input int total);
    int cyc;
    cyc = 0;
    while ((rec_done - base) < total && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    chk("records_served", rec_done - base, total);
    repeat (4) @(negedge clk);
    #3;
    chk("rec_cnt", rec_cnt, total);
    chk("grants_left", exp_ch.size(), 0);
  endtask

  // Read controller + DPRAM consumer; also streams random sample words.
  initial begin : responder
    int st, dly, bcnt, left;
    rc_ack = 1'b0; rc_more = 1'b0; rc_len = '0; dpram_busy = 1'b0;
    rc_wvb_rdreq = 1'b0; rc_wvb_rddone = 1'b0; wvb_data = '0; rec_done = 0;
    st = 0; dly = 0; bcnt = 0; left = 1;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) wvb_data[i*DW +: DW] = DW'($urandom);
      rc_wvb_rdreq  = 1'($urandom);
      rc_wvb_rddone = 1'($urandom);
      if (abort) begin
        rc_ack = 1'b0; rc_more = 1'b0; dpram_busy = 1'b0; st = 0; dly = 0;
        left = dpram_mode ? 1 + int'($urandom_range(0, 2)) : 1;
        exp_len.delete();
      end else begin
        case (st)
          0: if (rc_req) begin
               if (dly > 0) dly--;
               else begin
                 rc_ack  = 1'b1;
                 rc_len  = 16'($urandom);
                 rc_more = dpram_mode ? (left > 1) : 1'($urandom);
                 exp_len.push_back(int'(rc_len));
                 st = 1;
               end
             end
          1: begin rc_ack = 1'b0; st = 2; end
          2: if (dpram_run) begin
               dpram_busy = 1'b1;
               bcnt = 1 + int'($urandom_range(0, 5));
               st = 3;
             end
          3: begin
               bcnt--;
               if (bcnt == 0) begin
                 dpram_busy = 1'b0;
                 left--;
                 if (left == 0) begin
                   rec_done++;
                   left = dpram_mode ? 1 + int'($urandom_range(0, 2)) : 1;
                 end
                 dly = int'($urandom_range(0, 3));
                 st = 0;
               end
             end
          default: st = 0;
        endcase
      end
    end
  end

  initial begin : monitor
    int ch;
    for (int i = 0; i < N; i++) popped[i] = 0;
    cur_ch = 0; hist1 = '0; hist2 = '0;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (hdr_rdreq != '0) begin
          if (exp_ch.size() == 0) chk("unexpected_hdr_rdreq", hdr_rdreq, 0);
          else begin
            ch = exp_ch.pop_front();
            chk("hdr_rdreq", hdr_rdreq, N'(1) << ch);
            cur_ch = ch;
          end
        end
        if (dpram_run) begin
          if (exp_len.size() == 0) chk("unexpected_dpram_run", dpram_run, 0);
          else chk("dpram_len", dpram_len, exp_len.pop_front());
          chk("rc_idx", rc_idx, cur_ch);
          chk("rc_hdr", rc_hdr, hdr_data[cur_ch*HW +: HW]);
        end
        if (dpram_busy) begin
          chk("rc_wvb", rc_wvb, hist2[cur_ch*DW +: DW]);
          chk("wvb_rdreq", wvb_rdreq, rc_wvb_rdreq ? N'(1) << cur_ch : '0);
          chk("wvb_rddone", wvb_rddone, rc_wvb_rddone ? N'(1) << cur_ch : '0);
        end
      end
      for (int i = 0; i < N; i++) if (hdr_rdreq[i]) popped[i]++;
      hist2 = hist1;
      hist1 = wvb_data;
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: time limit reached, %0d compared / %0d bad", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int total, old, cyc;
    logic [N-1:0] m;
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; en = 1'b1; chan_mask = '0; dpram_mode = 1'b0; hdr_data = '0;
    mon_en = 1'b0; abort = 1'b1;
    for (int i = 0; i < N; i++) loaded[i] = 0;
    repeat (3) @(negedge clk);
    #3;
    reset_checks("por");

    // Burst of 4 on ch3, rotate to ch5, back to ch3 for the remaining two.
    loaded[3] += 6; loaded[5] += 2;
    begin_round(1'b1, 8'hFF, 8'hFF, 1'b0, total);
    finish_round(total);

    // ch3 masked off until ch1 has been granted.
    old = popped[1];
    loaded[1] += 1; loaded[3] += 2;
    begin_round(1'b1, 8'hF7, 8'hFF, 1'b1, total);
    cyc = 0;
    while (popped[1] == old && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("ch1_granted_under_mask", popped[1] - old, 1);
    chan_mask = 8'hFF;
    finish_round(total);

    // Reset while the DPRAM is busy on a second ch0 record.
    loaded[0] += 3; loaded[4] += 1;
    begin_round(1'b1, 8'hFF, 8'hFF, 1'b0, total);
    cyc = 0;
    while ((rec_done - base) < 1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    cyc = 0;
    #1;
    while (!dpram_busy && cyc < 300) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("busy_before_reset", dpram_busy, 1);
    @(negedge clk);
    mon_en = 1'b0;
    abort  = 1'b1;
    rst_n  = 1'b0;
    @(negedge clk);
    #3;
    reset_checks("mid");
    begin_round(1'b1, 8'hFF, 8'hFF, 1'b0, total);
    finish_round(total);

    // Random fill levels, masks, modes and reset sources.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) loaded[i] += int'($urandom_range(0, 3));
      m = N'($urandom) | (N'(1) << (r % N));
      begin_round(r != 2, m, m, r[0], total);
      finish_round(total);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
